// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer
//
// Multi-cycle controller for the EX-stage multiply path. When the decoder
// flags a multiply, both operands are latched and an iterative shift-add
// multiply runs, one multiplier bit per cycle. It stops early once no set
// multiplier bits remain. The pipeline is held through `stall` while the
// multiply runs. On completion the truncated product is presented for one
// cycle, together with an optional N/Z flag write.
//
// WIDTH must be a power of two and at least 4.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   mult         in   instruction in EX is a multiply (level)
//   flush        in   instruction in EX is squashed; aborts immediately
//   psr_wen_in   in   multiply updates flags (sampled at start)
//   srcA         in   multiplicand (sampled at start)
//   srcB         in   multiplier (sampled at start)
//   stall        out  hold IF/ID/EX (combinational)
//   busy         out  multiply iterations in progress
//   result       out  low WIDTH bits of srcA*srcB; held until next start
//   result_valid out  one-cycle pulse, result is final
//   psr_wen_out  out  one-cycle pulse, write N/Z (only if psr_wen_in at start)
//   psr_n        out  result[WIDTH-1]
//   psr_z        out  result == 0
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | waiting for a multiply
// RUN   | iterative shift-add in progress
// DONE  | result presented for one cycle, then IDLE

module ex_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult,
    input  logic             flush,
    input  logic             psr_wen_in,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             psr_wen_out,
    output logic             psr_n,
    output logic             psr_z
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             wen_q;

    logic             start;
    logic             last_step;
    logic [WIDTH-1:0] addend;

    // A start is only accepted from IDLE; a squashed multiply never starts.
    assign start = (state == S_IDLE) && mult && !flush;

    // Terminate after the step that consumes the last remaining set bit of
    // the multiplier, or after the final bit position.
    assign last_step = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);

    assign addend = mplier[0] ? mcand : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        psr_wen_out  = 1'b0;

        unique case (state)
            S_IDLE: begin
                stall = start;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = !flush;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // The multiply leaves EX this cycle, so never re-arm here even
                // if mult is still high; the next instruction starts from IDLE.
                result_valid = !flush;
                psr_wen_out  = wen_q && !flush;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            wen_q  <= 1'b0;
        end else if (start) begin
            mcand  <= srcA;
            mplier <= srcB;
            acc    <= '0;
            cnt    <= '0;
            wen_q  <= psr_wen_in;
        end else if ((state == S_RUN) && !flush) begin
            // Carry out of the top bit is discarded: only the low WIDTH bits
            // of the product are architecturally visible.
            acc    <= acc + addend;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
        end
    end

    assign result = acc;
    assign psr_n  = acc[WIDTH-1];
    assign psr_z  = (acc == '0);

endmodule

// File: doc/ex_mul_sequencer.md
# ex_mul_sequencer

Multi-cycle controller for the EX stage multiply path. It latches both operands when the decoder flags a multiply, then runs an iterative shift-add multiply with early termination. While it runs it holds the pipeline through `stall`, and on completion it presents the truncated product plus N/Z flag updates to the PSR. It sits beside the EX datapath: decoder `mult` and register operands come in; result, flag-write strobe and pipeline stall go out.

## Interface
- `WIDTH`, 32: operand and product width. Must be a power of two and ≥ 4.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mult` input 1: the instruction currently in EX is a multiply (level, from the decoder).
- `flush` input 1: the instruction in EX is squashed (branch taken or exception). Synchronous abort.
- `psr_wen_in` input 1: the multiply instruction updates flags. Sampled at start.
- `srcA` input WIDTH: multiplicand. Sampled at start.
- `srcB` input WIDTH: multiplier. Sampled at start.
- `stall` output 1: hold IF/ID/EX; combinational.
- `busy` output 1: FSM in RUN (registered-state decode).
- `result` output WIDTH: low WIDTH bits of `srcA*srcB`. Holds its value until the next start.
- `result_valid` output 1: one-cycle pulse, `result` is final.
- `psr_wen_out` output 1: one-cycle pulse, write N/Z. Only asserted if `psr_wen_in` was set at start.
- `psr_n` output 1: `result[WIDTH-1]`.
- `psr_z` output 1: `result == 0`.

## Operation
- FSM states:
  - IDLE: waiting for a multiply.
  - RUN: iterative multiply in progress.
  - DONE: result presented.
- Internal registers:
  - `mcand` (WIDTH): multiplicand, shifted left.
  - `mplier` (WIDTH): multiplier, shifted right.
  - `acc` (WIDTH): accumulator; drives `result`.
  - `cnt` (log2 WIDTH bits): step count.
  - `wen_q` (1): latched `psr_wen_in`.
- IDLE with `mult`=1 and `flush`=0 (start):
  - `mcand`←srcA, `mplier`←srcB, `acc`←0, `cnt`←0, `wen_q`←`psr_wen_in`.
  - Next state RUN.
- Each RUN cycle:
  - If `mplier[0]`: `acc`←`acc`+`mcand`, mod 2^WIDTH with carry discarded.
  - `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`←`cnt`+1.
  - Leave for DONE when `cnt`==WIDTH-1 or (`mplier`>>1)==0; otherwise stay in RUN.
- DONE:
  - `result_valid`=1, and `psr_wen_out`=`wen_q`.
  - Next state is always IDLE, even if `mult` is still high. The instruction that was just multiplied leaves EX at the end of this cycle.
- `stall` = (IDLE & `mult` & ~`flush`) | (RUN & ~`flush`). It is low in DONE, so the pipeline advances with the result.
- `flush` in any state: next state IDLE, no `result_valid`/`psr_wen_out`. `result` keeps its partial value, which is don't-care.
- Overflow bits above WIDTH are discarded. Arithmetic is unsigned; the low WIDTH bits are identical for signed operands.

## Timing
- Reset values: state IDLE, `acc`/`result`=0, `cnt`=0, `wen_q`=0, `busy`=0, `result_valid`=0, `psr_wen_out`=0.
  - `psr_z`=1 and `psr_n`=0, since both are derived from `result`.
  - `stall`=0 unless `mult` is high.
- Define k = max(1, 1 + index of the highest set bit of srcB). k ranges 1..WIDTH.
- Start in cycle C:
  - RUN in cycles C+1 .. C+k.
  - DONE in cycle C+k+1.
  - `stall` is high in cycles C .. C+k, i.e. k+1 cycles.
  - Total latency from start to `result_valid` is k+1 cycles.
- Back-to-back multiplies: the new `mult` is seen in IDLE at C+k+2 and starts immediately. There is no dead cycle beyond DONE.
- `reset` overrides everything, including mid-RUN: next cycle is IDLE with reset values.
- `flush` together with `mult` in IDLE: no start and `stall`=0.
- `flush` in the DONE cycle: suppresses `result_valid` and `psr_wen_out` in that cycle.

## Test plan
- srcA=3, srcB=5, `psr_wen_in`=1, start at C:
  - k=3, so `stall` is high in C..C+3.
  - DONE at C+4 with `result`=15, `result_valid`=1, `psr_wen_out`=1, N=0, Z=0.
- srcA=0x1234, srcB=0:
  - k=1, so `stall` lasts 2 cycles.
  - `result`=0, Z=1.
  - With `psr_wen_in`=0, `psr_wen_out` stays 0 throughout.
- srcA=srcB=0xFFFFFFFF:
  - 32 RUN cycles, DONE at C+33.
  - `result`=0x00000001, N=0.
- srcA=0x40000000, srcB=2:
  - `result`=0x80000000, N=1.
- Start 7×9, then assert `flush` at C+2:
  - `stall` drops in that cycle and state is IDLE at C+3.
  - No `result_valid`.
  - A following `mult` of 2×2 yields 4 with normal latency.
- Reset mid-RUN at C+5 of a 32-step multiply:
  - All outputs at reset values the next cycle.
- Back-to-back:
  - 6×6 then 5×1, with `mult` held high across both.
  - Two `result_valid` pulses, carrying 36 then 5.
  - The second start occurs the cycle after the first DONE.
